// File: rtl/window_frame_sched.sv
// Round-robin frame scheduler sharing one windower among NUM_SRC sources; holds a drain gap after each frame.
// Optional WFS_STALL_CNT_EN adds a per-frame stall_cnt output.
module window_frame_sched #(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int WINDOW        = 3,
  parameter int PADDING       = 1,
  parameter int NUM_SRC       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NO_CH-1:0]           src_data [NUM_SRC-1:0][THROUGHPUT-1:0],
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       win_vld,
  output logic [NO_CH-1:0]           win_data [THROUGHPUT-1:0],
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       frame_done
`ifdef WFS_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int BEATS = (2 ** LOG2_IMG_SIZE) / THROUGHPUT;
  localparam int PAD   = (PADDING != 0) ? (WINDOW - 1) / 2 : 0;
  localparam int GAP   = PAD + 1;
  localparam int CNT_W = LOG2_IMG_SIZE - $clog2(THROUGHPUT) + 1;
  localparam int GAP_W = $clog2(GAP + 1);
  localparam int ID_W  = $clog2(NUM_SRC);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   sel;
  logic              found;
  int unsigned       rr_idx;
  logic [CNT_W-1:0]  beat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              accept;
  logic              last_beat;
  logic              start;

  // Round-robin search begins just after the previous grant.
  always_comb begin
    sel    = last_grant;
    found  = 1'b0;
    rr_idx = 0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      rr_idx = (32'(last_grant) + i) % NUM_SRC;
      if (!found && src_req[ID_W'(rr_idx)]) begin
        sel   = ID_W'(rr_idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    accept    = (state == STREAM) && src_valid[grant_id];
    last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    start     = (state == IDLE) && (|src_req);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    src_ready = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:   if (|src_req) state_nxt = STREAM;
      STREAM: begin
        src_ready[grant_id] = 1'b1;
        if (accept && last_beat) state_nxt = DRAIN;
      end
      DRAIN:  if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_SRC - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      win_vld    <= 1'b0;
      win_data   <= '{default: '0};
      frame_done <= 1'b0;
    end else begin
      win_vld    <= accept;
      frame_done <= accept && last_beat;
      if (accept) begin
        win_data <= src_data[grant_id];
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (start) begin
        grant_id   <= sel;
        last_grant <= sel;
        beat_cnt   <= '0;
      end
      if (accept && last_beat) gap_cnt <= GAP_W'(GAP);
      else if (state == DRAIN)  gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef WFS_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                             stall_cnt <= '0;
    else if (start)                                      stall_cnt <= '0;
    else if (state == STREAM && !src_valid[grant_id] && stall_cnt != '1)
                                                         stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
